// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier with valid/ready handshakes on operands and result.
// Define SIGNED_MODE_EN to enable per-operation two's-complement handling via signed_mode.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;

    logic               accept;
    logic               last;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign accept  = (state_q == StIdle) && in_valid;
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    assign acc_sum = mplier_q[0] ? (acc_q + partial) : acc_q;

`ifdef SIGNED_MODE_EN
    logic neg_q;
    logic neg_d;

    // Magnitudes are WIDTH-bit unsigned, so the most-negative operand maps to 2^(WIDTH-1).
    assign a_mag  = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign neg_d  = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign result = neg_q ? (~acc_sum + 1'b1) : acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (accept) begin
            neg_q <= neg_d;
        end
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StRun;
            StRun:  if (last) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == StRun) begin
            acc_q    <= acc_sum;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
                product_q <= result;
            end
        end
    end

    assign product = product_q;

endmodule
